// File: rtl/stack_dmem_responder_pkg.sv
// Shared types and widths for the stack data-memory responder.
//   state_e      : responder FSM states
//   step_class_e : what the selected requester wants this cycle
//   DATA_W/BADDR_W/REG_W : data, byte-address and register-index widths
package stack_dmem_responder_pkg;

  localparam int DATA_W  = 32;
  localparam int BADDR_W = 16;
  localparam int REG_W   = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  // CLS_NULL with is_stack=1 is a stack step that needs no memory access;
  // CLS_NULL with is_stack=0 means nobody is asking.
  typedef enum logic [1:0] {
    CLS_NULL = 2'd0,
    CLS_WR   = 2'd1,
    CLS_RD   = 2'd2
  } step_class_e;

endpackage

// File: rtl/stack_dmem_responder_dmem_req_mux.sv
// Combinational source select and tag formation.
// The stack controller (mem_force) always wins over the core. The selected
// request is reduced to a word address, write data, writeback tag and a
// step class.
//   in : mem_force, st_* (stack request), core_* (core request)
//   out: sel_addr (word address), sel_wdata, sel_rdest, sel_rf_wr,
//        sel_pc_wr, sel_class, sel_stack
module dmem_req_mux
  import stack_dmem_responder_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic               mem_force,
  input  logic               st_wr,
  input  logic [BADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0]  st_wdata,
  input  logic [REG_W-1:0]   st_rdest,
  input  logic               st_rf_wr,
  input  logic               st_pc_wr,
  input  logic               core_req,
  input  logic               core_wr,
  input  logic [BADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0]  core_wdata,
  input  logic [REG_W-1:0]   core_rdest,
  output logic [ADDR_W-1:0]  sel_addr,
  output logic [DATA_W-1:0]  sel_wdata,
  output logic [REG_W-1:0]   sel_rdest,
  output logic               sel_rf_wr,
  output logic               sel_pc_wr,
  output step_class_e        sel_class,
  output logic               sel_stack
);

  logic [BADDR_W-1:0]  byte_addr;
  logic [ADDR_W+1:0]   byte_addr_fit;

  always_comb begin
    byte_addr = '0;
    sel_wdata = '0;
    sel_rdest = '0;
    sel_rf_wr = 1'b0;
    sel_pc_wr = 1'b0;
    sel_class = CLS_NULL;
    sel_stack = mem_force;
    if (mem_force) begin
      byte_addr = st_addr;
      sel_wdata = st_wdata;
      sel_rdest = st_rdest;
      if (st_wr) begin
        sel_class = CLS_WR;
      end else if (st_rf_wr || st_pc_wr) begin
        sel_class = CLS_RD;
        // A PC load takes precedence; the register file is not written.
        sel_pc_wr = st_pc_wr;
        sel_rf_wr = st_rf_wr & ~st_pc_wr;
      end
    end else if (core_req) begin
      byte_addr = core_addr;
      sel_wdata = core_wdata;
      sel_rdest = core_rdest;
      sel_class = core_wr ? CLS_WR : CLS_RD;
      sel_rf_wr = ~core_wr;
    end
  end

  // Fit the byte address to ADDR_W+2 bits (truncate or zero-extend), then
  // drop the byte-lane bits: all accesses are whole words.
  assign byte_addr_fit = (ADDR_W + 2)'(byte_addr);
  assign sel_addr      = byte_addr_fit[ADDR_W+1:2];

endmodule

// File: rtl/stack_dmem_responder.sv
// Data-memory responder for stack-controller forced accesses and core
// loads/stores. Owns the synchronous SRAM port.
//   Write: accept in IDLE, SRAM write + completion pulse next cycle.
//   Read : accept in IDLE, SRAM read next cycle, RD_LAT-1 wait cycles,
//          then writeback + completion pulse.
//   Null stack step: st_wen pulses combinationally in IDLE.
// Handshake: a requester raises its request and holds every field stable
// until it sees its one-cycle completion pulse (st_wen for the stack
// controller, core_ready for the core); requests are only looked at in IDLE.
// Ports:
//   clk, reset (sync, active-high)
//   mem_force, st_* : stack controller request
//   core_*          : core request
//   st_wen, core_ready : completion pulses;  busy : access in flight
//   mem_*           : SRAM port (mem_rdata valid RD_LAT cycles after mem_en)
//   wb_*            : writeback (one-cycle wb_valid)
//   dbg_state       : current FSM state
// RD_LAT legal range is 1..4.
module stack_dmem_responder
  import stack_dmem_responder_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_force,
  input  logic               st_wr,
  input  logic [BADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0]  st_wdata,
  input  logic [REG_W-1:0]   st_rdest,
  input  logic               st_rf_wr,
  input  logic               st_pc_wr,
  input  logic               core_req,
  input  logic               core_wr,
  input  logic [BADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0]  core_wdata,
  input  logic [REG_W-1:0]   core_rdest,
  output logic               st_wen,
  output logic               core_ready,
  output logic               busy,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               wb_valid,
  output logic [REG_W-1:0]   wb_addr,
  output logic [DATA_W-1:0]  wb_data,
  output logic               wb_rf_wr,
  output logic               wb_pc_wr,
  output logic [2:0]         dbg_state
);

  // Last value of the wait counter before moving to RESP.
  localparam int         WAIT_LAST_I = (RD_LAT >= 2) ? (RD_LAT - 2) : 0;
  localparam logic [1:0] WAIT_LAST   = 2'(WAIT_LAST_I);

  state_e             state_q, state_d;
  logic [1:0]         cnt_q;
  logic               accept;

  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [REG_W-1:0]   sel_rdest;
  logic               sel_rf_wr;
  logic               sel_pc_wr;
  step_class_e        sel_class;
  logic               sel_stack;

  logic [ADDR_W-1:0]  lat_addr;
  logic [DATA_W-1:0]  lat_wdata;
  logic [REG_W-1:0]   lat_rdest;
  logic               lat_rf_wr;
  logic               lat_pc_wr;
  logic               lat_stack;

  dmem_req_mux #(
    .ADDR_W (ADDR_W)
  ) u_req_mux (
    .mem_force  (mem_force),
    .st_wr      (st_wr),
    .st_addr    (st_addr),
    .st_wdata   (st_wdata),
    .st_rdest   (st_rdest),
    .st_rf_wr   (st_rf_wr),
    .st_pc_wr   (st_pc_wr),
    .core_req   (core_req),
    .core_wr    (core_wr),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdest (core_rdest),
    .sel_addr   (sel_addr),
    .sel_wdata  (sel_wdata),
    .sel_rdest  (sel_rdest),
    .sel_rf_wr  (sel_rf_wr),
    .sel_pc_wr  (sel_pc_wr),
    .sel_class  (sel_class),
    .sel_stack  (sel_stack)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_rdest <= '0;
      lat_rf_wr <= 1'b0;
      lat_pc_wr <= 1'b0;
      lat_stack <= 1'b0;
    end else begin
      state_q <= state_d;
      // Counts cycles spent in WAIT; cleared everywhere else.
      if (state_q == S_WAIT && state_d == S_WAIT) begin
        cnt_q <= cnt_q + 2'd1;
      end else begin
        cnt_q <= '0;
      end
      if (accept) begin
        lat_addr  <= sel_addr;
        lat_wdata <= sel_wdata;
        lat_rdest <= sel_rdest;
        lat_rf_wr <= sel_rf_wr;
        lat_pc_wr <= sel_pc_wr;
        lat_stack <= sel_stack;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    st_wen     = 1'b0;
    core_ready = 1'b0;
    busy       = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    wb_valid   = 1'b0;
    wb_addr    = '0;
    wb_data    = '0;
    wb_rf_wr   = 1'b0;
    wb_pc_wr   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Gated by reset so the combinational null-step pulse cannot
        // appear while the block is being reset.
        if (!reset) begin
          unique case (sel_class)
            CLS_WR: begin
              accept  = 1'b1;
              state_d = S_WRITE;
            end
            CLS_RD: begin
              accept  = 1'b1;
              state_d = S_READ;
            end
            default: st_wen = sel_stack;
          endcase
        end
      end
      S_WRITE: begin
        busy       = 1'b1;
        mem_en     = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = lat_addr;
        mem_wdata  = lat_wdata;
        st_wen     = lat_stack;
        core_ready = ~lat_stack;
        state_d    = S_IDLE;
      end
      S_READ: begin
        busy     = 1'b1;
        mem_en   = 1'b1;
        mem_addr = lat_addr;
        state_d  = (RD_LAT <= 1) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (cnt_q == WAIT_LAST) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        busy       = 1'b1;
        wb_valid   = 1'b1;
        wb_data    = mem_rdata;
        wb_addr    = lat_rdest;
        wb_rf_wr   = lat_rf_wr;
        wb_pc_wr   = lat_pc_wr;
        st_wen     = lat_stack;
        core_ready = ~lat_stack;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_stack_dmem_responder.sv
module tb_stack_dmem_responder;

  localparam int ADDR_W = 14;
  localparam int RD_LAT = 2;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        mem_force, st_wr, st_rf_wr, st_pc_wr;
  logic [15:0] st_addr;
  logic [31:0] st_wdata;
  logic [2:0]  st_rdest;
  logic        core_req, core_wr;
  logic [15:0] core_addr;
  logic [31:0] core_wdata;
  logic [2:0]  core_rdest;
  logic        st_wen, core_ready, busy, mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        wb_valid, wb_rf_wr, wb_pc_wr;
  logic [2:0]  wb_addr;
  logic [31:0] wb_data;
  logic [2:0]  dbg_state;

  stack_dmem_responder #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .mem_force(mem_force), .st_wr(st_wr), .st_addr(st_addr), .st_wdata(st_wdata),
    .st_rdest(st_rdest), .st_rf_wr(st_rf_wr), .st_pc_wr(st_pc_wr),
    .core_req(core_req), .core_wr(core_wr), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdest(core_rdest),
    .st_wen(st_wen), .core_ready(core_ready), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_rf_wr(wb_rf_wr), .wb_pc_wr(wb_pc_wr), .dbg_state(dbg_state)
  );

  // SRAM model: write on enable, read data appears RD_LAT cycles after
  // mem_en; junk on every other cycle so mistimed captures show up.
  logic [31:0] sram [0:(1<<ADDR_W)-1];
  logic [31:0] rpipe [0:RD_LAT-1];
  always @(posedge clk) begin
    if (mem_en && mem_we) sram[mem_addr] <= mem_wdata;
    rpipe[0] <= (mem_en && !mem_we) ? sram[mem_addr] : $urandom;
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[RD_LAT-1];

  // reference model: memory contents as the requesters intend them
  logic [31:0] ref_mem [0:(1<<ADDR_W)-1];
  logic [31:0] exp_q[$];

  int total = 0;
  int bad = 0;
  int wen_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (st_wen === 1'b1) wen_cnt++;
    if (!reset) check("overlap", {31'b0, mem_en & wb_valid}, 32'd0);
  end

  task automatic clear_inputs();
    mem_force = 0; st_wr = 0; st_addr = 0; st_wdata = 0; st_rdest = 0;
    st_rf_wr = 0; st_pc_wr = 0;
    core_req = 0; core_wr = 0; core_addr = 0; core_wdata = 0; core_rdest = 0;
  endtask

  // Runs one transaction from the IDLE cycle to its completion pulse.
  // Entry and exit: just after a rising edge.
  task automatic run_txn(input bit stk, input bit wr, input logic [15:0] addr,
                         input logic [31:0] wd, input logic [2:0] rd,
                         input bit rf, input bit pc);
    bit is_null, is_rd;
    int lat;
    logic [ADDR_W-1:0] wa;
    logic [31:0] exp_d;
    is_null = stk && !wr && !rf && !pc;
    is_rd   = !wr && !is_null;
    lat     = is_null ? 0 : (wr ? 1 : 1 + RD_LAT);
    wa      = addr[15:2];
    if (stk) begin
      mem_force = 1; st_wr = wr; st_addr = addr; st_wdata = wd;
      st_rdest = rd; st_rf_wr = rf; st_pc_wr = pc;
    end else begin
      core_req = 1; core_wr = wr; core_addr = addr; core_wdata = wd; core_rdest = rd;
    end
    if (is_rd) exp_q.push_back(ref_mem[wa]);
    if (wr) ref_mem[wa] = wd;
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      check("busy", {31'b0, busy}, {31'b0, c > 0});
      check("mem_en", {31'b0, mem_en}, {31'b0, (c == 1) && !is_null});
      if (c == 1 && !is_null) begin
        check("mem_we", {31'b0, mem_we}, {31'b0, wr});
        check("mem_addr", 32'(mem_addr), 32'(wa));
        if (wr) check("mem_wdata", mem_wdata, wd);
      end
      check("st_wen", {31'b0, st_wen}, {31'b0, stk && c == lat});
      check("core_ready", {31'b0, core_ready}, {31'b0, !stk && c == lat});
      check("wb_valid", {31'b0, wb_valid}, {31'b0, is_rd && c == lat});
      if (is_rd && c == lat) begin
        exp_d = exp_q.pop_front();
        check("wb_data", wb_data, exp_d);
        check("wb_addr", 32'(wb_addr), 32'(rd));
        check("wb_pc_wr", {31'b0, wb_pc_wr}, {31'b0, stk && pc});
        check("wb_rf_wr", {31'b0, wb_rf_wr}, {31'b0, stk ? (rf && !pc) : 1'b1});
      end
      @(posedge clk); #1;
      if (c == lat) begin
        if (stk) begin
          mem_force = 0; st_wr = 0; st_addr = 0; st_wdata = 0;
          st_rdest = 0; st_rf_wr = 0; st_pc_wr = 0;
        end else begin
          core_req = 0; core_wr = 0; core_addr = 0; core_wdata = 0; core_rdest = 0;
        end
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_st_wen"}, {31'b0, st_wen}, 32'd0);
    check({tag, "_core_ready"}, {31'b0, core_ready}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_mem_en"}, {31'b0, mem_en}, 32'd0);
    check({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_wb_valid"}, {31'b0, wb_valid}, 32'd0);
    check({tag, "_wb_data"}, wb_data, 32'd0);
    check({tag, "_wb_addr"}, 32'(wb_addr), 32'd0);
    check({tag, "_wb_flags"}, {30'b0, wb_rf_wr, wb_pc_wr}, 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    int w0;
    int kind;
    logic [15:0] pool [0:5];
    logic [15:0] a;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      sram[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    for (int i = 0; i < RD_LAT; i++) rpipe[i] = 32'd0;
    pool[0] = 16'h0100; pool[1] = 16'h0104; pool[2] = 16'h00FC;
    pool[3] = 16'hFFFC; pool[4] = 16'h0400; pool[5] = 16'h2000;

    // reset
    reset = 1;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    mem_force = 1;  // null step request held during reset must not pulse
    @(negedge clk);
    check("reset_null_st_wen", {31'b0, st_wen}, 32'd0);
    @(posedge clk); #1;
    reset = 0;
    mem_force = 0;
    @(posedge clk); #1;

    // stack write, word address 0x3F
    run_txn(1, 1, 16'h00FC, 32'hDEADBEEF, 3'd0, 0, 0);
    @(negedge clk);
    check("after_write_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;

    // POP to PC: load 0x40 first
    run_txn(1, 1, 16'h0100, 32'h00000040, 3'd0, 0, 0);
    run_txn(1, 0, 16'h0100, 32'd0, 3'd7, 0, 1);

    // null step
    run_txn(1, 0, 16'h0000, 32'd0, 3'd0, 0, 0);

    // rf and pc both set: pc wins
    run_txn(1, 0, 16'h00FC, 32'd0, 3'd2, 1, 1);

    // priority: core store waits behind a stack read
    core_req = 1; core_wr = 1; core_addr = 16'h0400; core_wdata = 32'h12345678;
    run_txn(1, 0, 16'h00FC, 32'd0, 3'd3, 1, 0);
    run_txn(0, 1, 16'h0400, 32'h12345678, 3'd0, 0, 0);
    run_txn(0, 0, 16'h0400, 32'd0, 3'd4, 0, 0);

    // reset in WAIT
    mem_force = 1; st_addr = 16'h0100; st_rdest = 3'd5; st_rf_wr = 1;
    @(posedge clk); #1;   // READ
    @(posedge clk); #1;   // WAIT
    reset = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("midreset");
    @(posedge clk); #1;
    reset = 0;
    clear_inputs();
    repeat (4) begin
      @(negedge clk);
      check("post_reset_wb_valid", {31'b0, wb_valid}, 32'd0);
      check("post_reset_st_wen", {31'b0, st_wen}, 32'd0);
      check("post_reset_busy", {31'b0, busy}, 32'd0);
    end
    @(posedge clk); #1;
    run_txn(1, 0, 16'h0100, 32'd0, 3'd5, 1, 0);

    // nine-step push
    w0 = wen_cnt;
    for (int i = 0; i < 9; i++)
      run_txn(1, 1, 16'h0300 - 16'(4 * (i + 1)), $urandom, 3'd0, 0, 0);
    check("push9_st_wen_count", 32'(wen_cnt - w0), 32'd9);

    // random mix
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 5);
      a = pool[$urandom_range(0, 5)] | 16'($urandom_range(0, 3));
      case (kind)
        0: run_txn(1, 0, a, 32'd0, 3'd0, 0, 0);
        1: run_txn(1, 1, a, $urandom, 3'd0, 0, 0);
        2: run_txn(1, 0, a, 32'd0, 3'($urandom_range(0, 7)), 1, 0);
        3: run_txn(0, 1, a, $urandom, 3'd0, 0, 0);
        4: run_txn(0, 0, a, 32'd0, 3'($urandom_range(0, 7)), 0, 0);
        default: run_txn(1, 0, a, 32'd0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1);
      endcase
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
